// File: rtl/fx_pkg.sv
// Shared definitions for the footswitch effect-select path: code constants,
// code helpers and the LED driver state encoding.
package fx_pkg;

  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_P1   = 3'd1;
  localparam logic [2:0] CODE_P2   = 3'd2;
  localparam logic [2:0] CODE_P3   = 3'd3;
  localparam logic [2:0] CODE_P4   = 3'd4;

  typedef enum logic [1:0] {
    LED_IDLE      = 2'd0,
    LED_BLINK_ON  = 2'd1,
    LED_BLINK_OFF = 2'd2,
    LED_STEADY    = 2'd3
  } led_state_t;

  function automatic logic code_valid(input logic [2:0] code);
    return (code >= CODE_P1) && (code <= CODE_P4);
  endfunction

  function automatic logic [3:0] code_to_onehot(input logic [2:0] code);
    logic [3:0] oh;
    case (code)
      CODE_P1: oh = 4'b0001;
      CODE_P2: oh = 4'b0010;
      CODE_P3: oh = 4'b0100;
      CODE_P4: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Timebase divider: one-cycle tick every DIV clocks; clr restarts the count
// so the first tick lands exactly DIV cycles after clr.
module tick_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/fx_led_driver.sv
// Effect-indicator LED driver: blink burst on each accepted selection, then a
// PWM-dimmed steady display of the selected LED.
module fx_led_driver #(
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_MS    = 100,
  parameter int BLINK_COUNT = 3,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          sel_code,
  input  logic                sel_valid,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [3:0]          led,
  output logic                busy,
  output logic                ack
);

  import fx_pkg::*;

  localparam int MS_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int BC_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(BLINK_MS - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_COUNT - 1);

  // Handshake: sel_valid is a one-cycle strobe with no back-pressure; a strobe
  // carrying a code in 1..4 is always taken and answered by ack one cycle later,
  // any other code is dropped silently.

  led_state_t          state, next_state;
  logic [2:0]          active_code, next_code;
  logic [MS_W-1:0]     ms_cnt, ms_next;
  logic [BC_W-1:0]     blink_cnt, blink_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                accept, tick, pwm_on;
  logic [3:0]          onehot, led_next;
  logic                busy_next;

  assign accept = sel_valid && code_valid(sel_code);
  assign pwm_on = (pwm_cnt < brightness) || (&brightness);

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LED_IDLE;
      active_code <= CODE_NONE;
      ms_cnt      <= '0;
      blink_cnt   <= '0;
      pwm_cnt     <= '0;
      led         <= 4'b0000;
      busy        <= 1'b0;
      ack         <= 1'b0;
    end else begin
      state       <= next_state;
      active_code <= next_code;
      ms_cnt      <= ms_next;
      blink_cnt   <= blink_next;
      pwm_cnt     <= pwm_cnt + 1'b1;
      led         <= led_next;
      busy        <= busy_next;
      ack         <= accept;
    end
  end

  // An accept restarts the burst from any state, including the same code.
  always_comb begin
    next_state = state;
    next_code  = active_code;
    ms_next    = ms_cnt;
    blink_next = blink_cnt;
    if (accept) begin
      next_state = LED_BLINK_ON;
      next_code  = sel_code;
      ms_next    = '0;
      blink_next = '0;
    end else begin
      case (state)
        LED_BLINK_ON, LED_BLINK_OFF: begin
          if (tick) begin
            if (ms_cnt == MS_LAST) begin
              ms_next = '0;
              if (state == LED_BLINK_ON) begin
                next_state = LED_BLINK_OFF;
              end else if (blink_cnt == BC_LAST) begin
                next_state = LED_STEADY;
              end else begin
                next_state = LED_BLINK_ON;
                blink_next = blink_cnt + 1'b1;
              end
            end else begin
              ms_next = ms_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // LED and busy registers follow the next state so they change with it.
  always_comb begin
    onehot    = code_to_onehot(next_code);
    led_next  = 4'b0000;
    busy_next = 1'b0;
    case (next_state)
      LED_BLINK_ON: begin
        led_next  = onehot;
        busy_next = 1'b1;
      end
      LED_BLINK_OFF: begin
        busy_next = 1'b1;
      end
      LED_STEADY: begin
        led_next = onehot & {4{pwm_on}};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fx_led_driver.sv
// Directed bench for fx_led_driver with a per-cycle expected-output queue.
module tb_fx_led_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sel_code = 3'd0;
  logic       sel_valid = 1'b0;
  logic [3:0] brightness = 4'd15;
  logic [3:0] led;
  logic       busy;
  logic       ack;

  logic [5:0] exp_q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         cnt_on;
  string      tag = "init";

  always #5 clk = ~clk;

  fx_led_driver #(
    .TICK_DIV    (4),
    .BLINK_MS    (2),
    .BLINK_COUNT (2),
    .PWM_BITS    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel_code   (sel_code),
    .sel_valid  (sel_valid),
    .brightness (brightness),
    .led        (led),
    .busy       (busy),
    .ack        (ack)
  );

  task automatic push_exp(input int n, input logic a, input logic b, input logic [3:0] l);
    for (int i = 0; i < n; i++) exp_q.push_back({a, b, l});
  endtask

  task automatic sample();
    logic [5:0] obs;
    logic [5:0] exp;
    @(posedge clk);
    #1;
    obs = {ack, busy, led};
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: output with empty queue observed %b", tag, obs);
    end
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      n_assert++;
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: {ack,busy,led} observed %b expected %b", tag, obs, exp);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      sel_valid = 1'b0;
    end
  endtask

  task automatic drive(input logic [2:0] code);
    sel_code  = code;
    sel_valid = 1'b1;
  endtask

  task automatic push_burst(input logic [3:0] oh);
    push_exp(1, 1'b1, 1'b1, oh);
    push_exp(7, 1'b0, 1'b1, oh);
    push_exp(8, 1'b0, 1'b1, 4'b0000);
    push_exp(8, 1'b0, 1'b1, oh);
    push_exp(8, 1'b0, 1'b1, 4'b0000);
    push_exp(4, 1'b0, 1'b0, oh);
  endtask

  initial begin
    // Reset held 3 cycles with a valid strobe present
    tag = "reset";
    sel_code  = 3'd3;
    sel_valid = 1'b1;
    push_exp(3, 1'b0, 1'b0, 4'b0000);
    repeat (3) sample();
    reset     = 1'b0;
    sel_valid = 1'b0;
    tag = "idle";
    push_exp(3, 1'b0, 1'b0, 4'b0000);
    run(3);

    tag = "burst_p3";
    drive(3'd3);
    push_burst(4'b0100);
    run(36);

    tag = "pwm_half";
    brightness = 4'd8;
    cnt_on = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      n_assert++;
      assert ((led === 4'b0100 || led === 4'b0000) && busy === 1'b0 && ack === 1'b0) else begin
        n_fail++;
        $error("FAIL %s: {ack,busy,led} observed %b expected 000100 or 000000", tag, {ack, busy, led});
      end
      if (led === 4'b0100) cnt_on++;
    end
    n_assert++;
    assert (cnt_on == 8) else begin
      n_fail++;
      $error("FAIL pwm_duty: on cycles observed %0d expected 8", cnt_on);
    end

    tag = "pwm_zero";
    brightness = 4'd0;
    push_exp(16, 1'b0, 1'b0, 4'b0000);
    run(16);

    tag = "pwm_full";
    brightness = 4'd15;
    push_exp(16, 1'b0, 1'b0, 4'b0100);
    run(16);

    tag = "invalid_0";
    drive(3'd0);
    push_exp(3, 1'b0, 1'b0, 4'b0100);
    run(3);
    tag = "invalid_5";
    drive(3'd5);
    push_exp(3, 1'b0, 1'b0, 4'b0100);
    run(3);
    tag = "invalid_7";
    drive(3'd7);
    push_exp(3, 1'b0, 1'b0, 4'b0100);
    run(3);

    tag = "retrig_p1";
    drive(3'd1);
    push_exp(1, 1'b1, 1'b1, 4'b0001);
    push_exp(4, 1'b0, 1'b1, 4'b0001);
    run(5);
    tag = "retrig_p4";
    drive(3'd4);
    push_burst(4'b1000);
    run(36);

    tag = "mid_blink";
    drive(3'd2);
    push_exp(1, 1'b1, 1'b1, 4'b0010);
    push_exp(2, 1'b0, 1'b1, 4'b0010);
    run(3);
    tag = "reset_mid";
    reset = 1'b1;
    drive(3'd2);
    push_exp(3, 1'b0, 1'b0, 4'b0000);
    run(3);
    reset = 1'b0;
    tag = "idle_after";
    push_exp(10, 1'b0, 1'b0, 4'b0000);
    run(10);
    tag = "post_reset_p4";
    drive(3'd4);
    push_exp(1, 1'b1, 1'b1, 4'b1000);
    push_exp(3, 1'b0, 1'b1, 4'b1000);
    run(4);

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: queue entries left %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
